// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core: fixed-priority stall/flush
// generation, hazard-class state register, saturating perf counters, MEM_WAIT watchdog.

module hazard_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  cnt <= '0;
    else if (inc && ~&cnt)    cnt <= cnt + 1'b1;
  end
endmodule

module hazard_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_use_rs1_i,
  input  logic                  id_use_rs2_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_mem_read_i,
  input  logic                  ex_branch_taken_i,
  input  logic                  mem_req_i,
  input  logic                  mem_ready_i,
  input  logic                  imem_ready_i,
  output logic                  pc_stall_o,
  output logic                  if_id_stall_o,
  output logic                  if_id_flush_o,
  output logic                  id_ex_flush_o,
  output logic                  ex_stall_o,
  output logic                  mem_wb_bubble_o,
  output logic [1:0]            state_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o,
  output logic                  mem_timeout_o
);
  localparam int WD_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_USE   = 2'd1,
    MEM_WAIT   = 2'd2,
    FETCH_WAIT = 2'd3
  } hz_e;

  hz_e             state_q, cls;
  logic            mem_wait, load_use, fetch_wait, branch;
  logic [WD_W-1:0] wd_cnt;

  always_comb begin
    mem_wait   = mem_req_i & ~mem_ready_i;
    load_use   = ex_mem_read_i && (ex_rd_i != '0) &&
                 ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                  (id_use_rs2_i && (id_rs2_i == ex_rd_i)));
    fetch_wait = ~imem_ready_i;
  end

  // Priority chain; a taken branch records as RUN but still flushes.
  always_comb begin
    cls             = RUN;
    branch          = 1'b0;
    pc_stall_o      = 1'b0;
    if_id_stall_o   = 1'b0;
    if_id_flush_o   = 1'b0;
    id_ex_flush_o   = 1'b0;
    ex_stall_o      = 1'b0;
    mem_wb_bubble_o = 1'b0;
    if (rst) begin
      cls = RUN;
    end else if (mem_wait) begin
      cls             = MEM_WAIT;
      pc_stall_o      = 1'b1;
      if_id_stall_o   = 1'b1;
      ex_stall_o      = 1'b1;
      mem_wb_bubble_o = 1'b1;
    end else if (ex_branch_taken_i) begin
      branch        = 1'b1;
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
    end else if (load_use) begin
      cls           = LOAD_USE;
      pc_stall_o    = 1'b1;
      if_id_stall_o = 1'b1;
      id_ex_flush_o = 1'b1;
    end else if (fetch_wait) begin
      cls           = FETCH_WAIT;
      pc_stall_o    = 1'b1;
      if_id_flush_o = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= cls;
  end

  assign state_o = state_q;

  // Watchdog counts consecutive MEM_WAIT cycles; holds at the limit so it cannot wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt        <= '0;
      mem_timeout_o <= 1'b0;
    end else if (cls == MEM_WAIT) begin
      if (wd_cnt != WD_W'(MEM_TIMEOUT)) wd_cnt <= wd_cnt + 1'b1;
      if (wd_cnt == WD_W'(MEM_TIMEOUT - 1)) mem_timeout_o <= 1'b1;
    end else begin
      wd_cnt <= '0;
    end
  end

  hazard_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (pc_stall_o),
    .cnt (stall_cnt_o)
  );

  hazard_sat_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (branch),
    .cnt (flush_cnt_o)
  );
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed test-plan sequences plus random traffic,
// checked against a cycle-level priority model with integer counters.

module tb_hazard_ctrl;
  localparam int RW  = 5;
  localparam int CW  = 4;
  localparam int MT  = 4;
  localparam int MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [RW-1:0] rs1, rs2, rd;
  logic          u1, u2, mrd, bt, mq, mrdy, irdy;
  logic          pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_stall, mem_wb_bubble;
  logic [1:0]    state;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic          mem_timeout;

  hazard_ctrl #(.REG_ADDR_W(RW), .CNT_W(CW), .MEM_TIMEOUT(MT)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_i(rs1), .id_rs2_i(rs2), .id_use_rs1_i(u1), .id_use_rs2_i(u2),
    .ex_rd_i(rd), .ex_mem_read_i(mrd), .ex_branch_taken_i(bt),
    .mem_req_i(mq), .mem_ready_i(mrdy), .imem_ready_i(irdy),
    .pc_stall_o(pc_stall), .if_id_stall_o(if_id_stall), .if_id_flush_o(if_id_flush),
    .id_ex_flush_o(id_ex_flush), .ex_stall_o(ex_stall), .mem_wb_bubble_o(mem_wb_bubble),
    .state_o(state), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt),
    .mem_timeout_o(mem_timeout)
  );

  typedef struct {
    logic rst; logic [RW-1:0] rs1, rs2, rd;
    logic u1, u2, mrd, bt, mq, mrdy, irdy;
  } stim_t;

  int n_cmp = 0, n_err = 0;
  // model state
  int m_state, m_stall, m_flush, m_wd;
  bit m_to;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // 0 RUN, 1 LOAD_USE, 2 MEM_WAIT, 3 FETCH_WAIT, 4 BRANCH
  function automatic int classify(input stim_t s);
    bit lu;
    lu = s.mrd && s.rd != 0 && ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
    if (s.mq && !s.mrdy) return 2;
    if (s.bt)            return 4;
    if (lu)              return 1;
    if (!s.irdy)         return 3;
    return 0;
  endfunction

  // {pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_stall, mem_wb_bubble}
  function automatic logic [5:0] ctrl_of(input int c);
    case (c)
      2: return 6'b110011;
      4: return 6'b001100;
      1: return 6'b110100;
      3: return 6'b101000;
      default: return 6'b000000;
    endcase
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.rst = 0; s.rs1 = 0; s.rs2 = 0; s.rd = 0;
    s.u1 = 0; s.u2 = 0; s.mrd = 0; s.bt = 0; s.mq = 0; s.mrdy = 1; s.irdy = 1;
    return s;
  endfunction

  task automatic run(input stim_t s);
    int c;
    logic [5:0] ex_ctrl;
    @(negedge clk);
    rst = s.rst; rs1 = s.rs1; rs2 = s.rs2; rd = s.rd; u1 = s.u1; u2 = s.u2;
    mrd = s.mrd; bt = s.bt; mq = s.mq; mrdy = s.mrdy; irdy = s.irdy;
    if (s.rst) begin
      m_state = 0; m_stall = 0; m_flush = 0; m_wd = 0; m_to = 0;
    end
    #2;
    c = classify(s);
    ex_ctrl = s.rst ? 6'b0 : ctrl_of(c);
    chk("ctrl", {pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_stall, mem_wb_bubble}, ex_ctrl);
    chk("state", state, m_state);
    chk("stall_cnt", stall_cnt, m_stall);
    chk("flush_cnt", flush_cnt, m_flush);
    chk("mem_timeout", mem_timeout, m_to);
    @(posedge clk);
    if (!s.rst) begin
      if (ex_ctrl[5] && m_stall < MAX) m_stall++;
      if (c == 4 && m_flush < MAX) m_flush++;
      m_state = (c == 4) ? 0 : c;
      if (c == 2) begin
        m_wd++;
        if (m_wd >= MT) m_to = 1;
      end else m_wd = 0;
    end
  endtask

  initial begin
    stim_t s;
    rst = 1; rs1 = 0; rs2 = 0; rd = 0; u1 = 0; u2 = 0;
    mrd = 0; bt = 0; mq = 0; mrdy = 1; irdy = 1;
    m_state = 0; m_stall = 0; m_flush = 0; m_wd = 0; m_to = 0;

    s = idle(); s.rst = 1; run(s); run(s);
    s = idle(); run(s);

    // load-use on rs2, then the bubble cycle
    s = idle(); s.mrd = 1; s.rd = 5; s.rs2 = 5; s.u2 = 1; run(s);
    s = idle(); run(s);
    // no false hazards: x0 destination, rs2 not used
    s = idle(); s.mrd = 1; s.rd = 0; s.rs2 = 0; s.u2 = 1; run(s);
    s = idle(); s.mrd = 1; s.rd = 5; s.rs2 = 5; s.u2 = 0; run(s);
    // branch beats load-use and fetch wait
    s = idle(); s.mrd = 1; s.rd = 7; s.rs1 = 7; s.u1 = 1; s.bt = 1; s.irdy = 0; run(s);
    // data-memory wait with a held branch, then release
    for (int i = 0; i < 3; i++) begin
      s = idle(); s.mq = 1; s.mrdy = 0; s.bt = 1; run(s);
    end
    s = idle(); s.mq = 1; s.mrdy = 1; s.bt = 1; run(s);
    s = idle(); run(s);

    // watchdog: 5 wait cycles, release, then an async reset mid-stream
    s = idle(); s.rst = 1; run(s);
    for (int i = 0; i < 5; i++) begin
      s = idle(); s.mq = 1; s.mrdy = 0; s.mrd = 1; s.rd = 3; s.rs1 = 3; s.u1 = 1; run(s);
    end
    s = idle(); s.mq = 1; s.mrd = 1; s.rd = 3; s.rs1 = 3; s.u1 = 1; run(s);
    s = idle(); run(s);
    s = idle(); s.rst = 1; s.mq = 1; s.mrdy = 0; run(s);
    s = idle(); run(s);

    // fetch wait long enough to saturate stall_cnt
    for (int i = 0; i < 20; i++) begin
      s = idle(); s.irdy = 0; run(s);
    end
    s = idle(); run(s);

    // random traffic on a small register set so matches are frequent
    for (int i = 0; i < 500; i++) begin
      s.rst  = ($urandom_range(0, 79) == 0);
      s.rs1  = RW'($urandom_range(0, 3));
      s.rs2  = RW'($urandom_range(0, 3));
      s.rd   = RW'($urandom_range(0, 3));
      s.u1   = 1'($urandom_range(0, 1));
      s.u2   = 1'($urandom_range(0, 1));
      s.mrd  = 1'($urandom_range(0, 1));
      s.bt   = ($urandom_range(0, 5) == 0);
      s.mq   = ($urandom_range(0, 1) == 0);
      s.mrdy = ($urandom_range(0, 2) != 0);
      s.irdy = ($urandom_range(0, 3) != 0);
      run(s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
